// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson code decoder: lock FSM states, phase-count helpers,
// and the legality/index decode that the counter's bench checker also uses.
package johnson_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        TRACK    = 2'd1,
        LOCKED   = 2'd2
    } jdec_state_t;

    localparam int JDEC_MAX_W = 32;

    function automatic int jdec_phases(input int width);
        return 2 * width;
    endfunction

    function automatic int jdec_idx_w(input int width);
        return (2 * width <= 2) ? 1 : $clog2(2 * width);
    endfunction

    // Index comes from the popcount and the MSB. The code is legal only if it matches
    // the canonical Johnson pattern for that index. Bits at and above 'width' must be zero.
    function automatic int jdec_decode(input logic [JDEC_MAX_W-1:0] q, input int width,
                                       output logic legal);
        int                    ones;
        int                    idx;
        logic [JDEC_MAX_W-1:0] exp_code;
        ones = 0;
        for (int b = 0; b < JDEC_MAX_W; b++) begin
            if (b < width && q[b]) ones++;
        end
        idx = q[width-1] ? (2 * width - ones) : ones;
        exp_code = '0;
        for (int b = 0; b < JDEC_MAX_W; b++) begin
            if (b < width) exp_code[b] = (idx <= width) ? (b < idx) : (b >= idx - width);
        end
        legal = (q == exp_code);
        return idx;
    endfunction

endpackage

// File: rtl/johnson_code_check.sv
// Combinational legality check and phase-index decode of one Johnson code word.
module johnson_code_check
    import johnson_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = 3
) (
    input  logic [WIDTH-1:0] q_in,
    output logic             legal,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        int   idx_full;
        logic legal_c;
        idx_full = jdec_decode(JDEC_MAX_W'(q_in), WIDTH, legal_c);
        legal    = legal_c;
        idx      = IDX_W'(idx_full);
    end

endmodule

// File: rtl/johnson_phase_decoder.sv
// Johnson code phase decoder with a lock FSM, error flags and a completed-cycle counter.
// The cycle counter is built only when JOHNSON_DEC_CYCLE_CNT_EN is defined; otherwise it reads 0.
module johnson_phase_decoder
    import johnson_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 3,
    parameter int CYCLE_W    = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [WIDTH-1:0]                q_in,
    input  logic                            q_valid,
    output logic [jdec_phases(WIDTH)-1:0]   phase_onehot,
    output logic [jdec_idx_w(WIDTH)-1:0]    phase_idx,
    output logic                            locked,
    output logic                            err,
    output logic                            err_sticky,
    output logic [CYCLE_W-1:0]              cycle_count
);

    localparam int P     = jdec_phases(WIDTH);
    localparam int IDX_W = jdec_idx_w(WIDTH);
    localparam int RUN_W = $clog2(LOCK_COUNT + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(P - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
    localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_COUNT);

    logic             code_legal;
    logic [IDX_W-1:0] code_idx;
    logic [IDX_W-1:0] succ_idx;
    logic             is_succ;

    jdec_state_t      state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [IDX_W-1:0] prev_idx_q, prev_idx_d;
    logic [IDX_W-1:0] phase_idx_q, phase_idx_d;
    logic [P-1:0]     onehot_q, onehot_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             sticky_q, sticky_d;

    johnson_code_check #(
        .WIDTH(WIDTH),
        .IDX_W(IDX_W)
    ) u_code_check (
        .q_in (q_in),
        .legal(code_legal),
        .idx  (code_idx)
    );

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case leaves it unassigned (no latch).
        state_d     = state_q;
        run_d       = run_q;
        prev_idx_d  = prev_idx_q;
        phase_idx_d = phase_idx_q;
        onehot_d    = onehot_q;
        err_d       = 1'b0;
        succ_idx    = (prev_idx_q == LAST_IDX) ? '0 : prev_idx_q + IDX_ONE;
        is_succ     = code_legal && (code_idx == succ_idx);

        if (q_valid) begin
            onehot_d = '0;
            if (code_legal) begin
                phase_idx_d        = code_idx;
                prev_idx_d         = code_idx;
                onehot_d[code_idx] = 1'b1;
            end

            case (state_q)
                UNLOCKED: begin
                    if (code_legal) begin
                        state_d = TRACK;
                        run_d   = RUN_ONE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                TRACK: begin
                    if (is_succ) begin
                        run_d = run_q + RUN_ONE;
                        if (run_d == RUN_LOCK) state_d = LOCKED;
                    end else if (code_legal) begin
                        run_d = RUN_ONE;
                        err_d = 1'b1;
                    end else begin
                        state_d = UNLOCKED;
                        run_d   = '0;
                        err_d   = 1'b1;
                    end
                end
                LOCKED: begin
                    if (!is_succ) begin
                        err_d = 1'b1;
                        if (code_legal) begin
                            state_d = TRACK;
                            run_d   = RUN_ONE;
                        end else begin
                            state_d = UNLOCKED;
                            run_d   = '0;
                        end
                    end
                end
                default: begin
                    state_d = UNLOCKED;
                    run_d   = '0;
                end
            endcase
        end

        sticky_d = sticky_q | err_d;
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= UNLOCKED;
            run_q       <= '0;
            prev_idx_q  <= '0;
            phase_idx_q <= '0;
            onehot_q    <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values computed above.
            state_q     <= state_d;
            run_q       <= run_d;
            prev_idx_q  <= prev_idx_d;
            phase_idx_q <= phase_idx_d;
            onehot_q    <= onehot_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            sticky_q    <= sticky_d;
        end
    end

    assign phase_onehot = onehot_q;
    assign phase_idx    = phase_idx_q;
    assign locked       = locked_q;
    assign err          = err_q;
    assign err_sticky   = sticky_q;

`ifdef JOHNSON_DEC_CYCLE_CNT_EN
    localparam logic [CYCLE_W-1:0] CYCLE_ONE = CYCLE_W'(1);

    logic [CYCLE_W-1:0] cycle_q, cycle_d;

    // A cycle completes on the locked successor that wraps the index back to 0.
    always_comb begin
        cycle_d = cycle_q;
        if (q_valid && state_q == LOCKED && is_succ && code_idx == '0) cycle_d = cycle_q + CYCLE_ONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cycle_q <= '0;
        else        cycle_q <= cycle_d;
    end

    assign cycle_count = cycle_q;
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Randomized self-checking bench for johnson_phase_decoder against a table-driven phase model.
module tb_johnson_phase_decoder;

    localparam int P = 8;
`ifdef JOHNSON_DEC_CYCLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [3:0] q_in;
    logic       q_valid;
    logic [7:0] phase_onehot;
    logic [2:0] phase_idx;
    logic       locked;
    logic       err;
    logic       err_sticky;
    logic [7:0] cycle_count;

    johnson_phase_decoder #(
        .WIDTH     (4),
        .LOCK_COUNT(3),
        .CYCLE_W   (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .q_in        (q_in),
        .q_valid     (q_valid),
        .phase_onehot(phase_onehot),
        .phase_idx   (phase_idx),
        .locked      (locked),
        .err         (err),
        .err_sticky  (err_sticky),
        .cycle_count (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: the legal codes are found by walking a twisted-ring shift, the phase is the table position.
    logic [3:0] code_tab[P];
    int         m_state;   // 0 unlocked, 1 tracking, 2 locked
    int         m_run;
    int         m_prev;
    int         m_idx;
    logic [7:0] m_onehot;
    bit         m_err;
    bit         m_sticky;
    int         m_cyc;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic bit lookup(input logic [3:0] c, output int ix);
        ix = 0;
        for (int i = 0; i < P; i++) begin
            if (code_tab[i] == c) begin
                ix = i;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_state  = 0;
        m_run    = 0;
        m_prev   = 0;
        m_idx    = 0;
        m_onehot = '0;
        m_err    = 1'b0;
        m_sticky = 1'b0;
        m_cyc    = 0;
    endtask

    task automatic model_step(input logic v, input logic [3:0] c);
        int ix;
        bit ok;
        bit succ;
        m_err = 1'b0;
        if (!v) return;
        ok   = lookup(c, ix);
        succ = ok && (ix == (m_prev + 1) % P);
        if (CNT_EN && m_state == 2 && succ && ix == 0) m_cyc = (m_cyc + 1) % 256;
        if (!ok) begin
            m_err = 1'b1;
            if (m_state != 0) begin
                m_state = 0;
                m_run   = 0;
            end
        end else if (m_state == 0) begin
            m_state = 1;
            m_run   = 1;
        end else if (!succ) begin
            m_err   = 1'b1;
            m_state = 1;
            m_run   = 1;
        end else if (m_state == 1) begin
            m_run = m_run + 1;
            if (m_run >= 3) m_state = 2;
        end
        if (ok) begin
            m_idx    = ix;
            m_prev   = ix;
            m_onehot = 8'h01 << ix;
        end else begin
            m_onehot = '0;
        end
        if (m_err) m_sticky = 1'b1;
    endtask

    task automatic check_all(input string tag);
        check({tag, "/onehot"}, phase_onehot, m_onehot);
        check({tag, "/idx"}, phase_idx, m_idx);
        check({tag, "/locked"}, locked, (m_state == 2));
        check({tag, "/err"}, err, m_err);
        check({tag, "/sticky"}, err_sticky, m_sticky);
        check({tag, "/cycles"}, cycle_count, m_cyc);
    endtask

    // Called just after a falling edge: drive, take one rising edge, check on the next falling edge.
    task automatic step(input logic v, input logic [3:0] c, input string tag);
        q_valid = v;
        q_in    = c;
        @(posedge clk);
        model_step(v, c);
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        logic [3:0] c;
        int         r;
        c = 4'b0000;
        for (int i = 0; i < P; i++) begin
            code_tab[i] = c;
            c = {c[2:0], ~c[3]};
        end

        reset   = 1'b0;
        q_valid = 1'b0;
        q_in    = 4'b0000;
        model_reset();
        #8;
        check_all("reset");
        #2;
        reset = 1'b1;

        // Clean lock followed by five full locked cycles.
        for (int k = 0; k < 48; k++) begin
            step(1'b1, code_tab[k % P], "clean");
            if (k == 0) check("onehot_code0", phase_onehot, 8'h01);
            if (k == 1) check("not_locked_2nd", locked, 1'b0);
            if (k == 2) check("locked_3rd", locked, 1'b1);
            if (k < P) check("idx_follow", phase_idx, k);
        end
        check("cycles_5", cycle_count, CNT_EN ? 5 : 0);

        // Illegal code while locked, then relock.
        step(1'b1, 4'b0101, "illegal");
        check("illegal_err", err, 1'b1);
        check("illegal_unlock", locked, 1'b0);
        check("illegal_onehot", phase_onehot, 8'h00);
        check("illegal_sticky", err_sticky, 1'b1);
        step(1'b1, code_tab[0], "relock");
        check("err_one_cycle", err, 1'b0);
        step(1'b1, code_tab[1], "relock");
        step(1'b1, code_tab[2], "relock");
        check("relocked", locked, 1'b1);

        // Skip a phase while locked: 0011 -> 1111.
        for (int k = 3; k < 11; k++) step(1'b1, code_tab[k % P], "pre_skip");
        step(1'b1, 4'b1111, "skip");
        check("skip_err", err, 1'b1);
        check("skip_unlock", locked, 1'b0);
        check("skip_idx", phase_idx, 4);
        step(1'b1, code_tab[5], "after_skip");
        check("run_restart", locked, 1'b0);
        step(1'b1, code_tab[6], "after_skip");
        check("run_relock", locked, 1'b1);

        // Sample strobe low with an illegal pattern on the bus.
        step(1'b0, 4'b1010, "gate");
        check("gate_err", err, 1'b0);
        check("gate_idx", phase_idx, 6);
        check("gate_locked", locked, 1'b1);

        // Asynchronous reset between clock edges.
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, code_tab[5], "first_after_rst");
        check("no_succ_check", err, 1'b0);

        // Randomized traffic: mostly successors, with jumps, raw patterns and idle strobes.
        for (int n = 0; n < 800; n++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      step(1'b1, code_tab[(m_prev + 1) % P], "rand_succ");
            else if (r < 80) step(1'b1, code_tab[$urandom_range(0, P - 1)], "rand_jump");
            else if (r < 90) step(1'b1, 4'($urandom_range(0, 15)), "rand_raw");
            else             step(1'b0, 4'($urandom_range(0, 15)), "rand_idle");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
